// File: rtl/alu_sequencer.sv
// alu_sequencer: command-level front end for the serial-bus 8-bit ALU
//   clk, reset         : clock, asynchronous active-high reset
//   cmd_valid/ready    : one whole operation per handshake (cmd_op, cmd_a, cmd_b)
//   rsp_valid/ready    : packed 16-bit result (rsp_data) and error code (rsp_err)
//   alu_reset, alu_begin, alu_op_code, alu_inbus : drive side of the ALU byte protocol
//   alu_outbus, alu_end                          : result side of the ALU byte protocol
module alu_sequencer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [1:0]  rsp_err,
  output logic        alu_reset,
  output logic        alu_begin,
  output logic [1:0]  alu_op_code,
  output logic [7:0]  alu_inbus,
  input  logic [7:0]  alu_outbus,
  input  logic        alu_end
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLR     = 3'd1;
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] COLLECT = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;
  localparam logic [1:0] OP_DIV  = 2'b11;
  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_DZ  = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;
  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [15:0]      a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [1:0]       k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       r0_q, r0_d;
  logic [15:0]      rsp_data_d;
  logic [1:0]       rsp_err_d;
  logic             is_div, last_k, timeout;
  logic [7:0]       byte_k;
  assign is_div  = op_q == OP_DIV;
  assign last_k  = k_q == (is_div ? 2'd2 : 2'd1);
  assign timeout = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  // Operand byte for the index that will be on inbus next cycle.
  assign byte_k  = is_div ? (k_d == 2'd0 ? a_q[15:8] : k_d == 2'd1 ? a_q[7:0] : b_q)
                          : (k_d == 2'd0 ? a_q[7:0] : b_q);
  // Combinational so the ALU is cleared as soon as reset is asserted.
  assign alu_reset = reset | (state_q == CLR);
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    r0_d       = r0_q;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        op_d = cmd_op;
        a_d  = cmd_a;
        b_d  = cmd_b;
        if (cmd_op == OP_DIV && cmd_b == 8'h00) begin
          state_d    = RESP;
          rsp_data_d = '0;
          rsp_err_d  = ERR_DZ;
        end else begin
          state_d = CLR;
        end
      end
      CLR: begin
        state_d = LOAD;
        k_d     = 2'd0;
      end
      LOAD: begin
        k_d = k_q + 2'd1;
        if (last_k) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // END has priority over the watchdog when both land in the same cycle.
        if (alu_end) begin
          r0_d       = alu_outbus;
          state_d    = op_q[1] ? COLLECT : RESP;
          rsp_data_d = {8'h00, alu_outbus};
          rsp_err_d  = ERR_OK;
        end else if (timeout) begin
          state_d    = RESP;
          rsp_data_d = '0;
          rsp_err_d  = ERR_TO;
        end
      end
      COLLECT: begin
        state_d    = RESP;
        rsp_data_d = {r0_q, alu_outbus};
        rsp_err_d  = ERR_OK;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Interface outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      r0_q        <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= '0;
      alu_begin   <= 1'b0;
      alu_op_code <= '0;
      alu_inbus   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      r0_q        <= r0_d;
      cmd_ready   <= state_d == IDLE;
      rsp_valid   <= state_d == RESP;
      rsp_data    <= rsp_data_d;
      rsp_err     <= rsp_err_d;
      alu_begin   <= state_d == LOAD && k_d == 2'd0;
      alu_op_code <= state_d == LOAD ? op_q : alu_op_code;
      alu_inbus   <= state_d == LOAD ? byte_k : alu_inbus;
    end
  end
endmodule
